// File: rtl/xbus_arbiter_if.sv
// Master-side request/ack and decoder-side select/data signals of the shared bus.
// slave = arbiter view; master = view of the agents (masters and decoder) around it.
interface xbus_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) ();
  logic              m0_req;
  logic              m0_lock;
  logic [ADDR_W-1:0] m0_addr;
  logic              m0_we;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_ack;
  logic              m0_err;
  logic              m1_req;
  logic              m1_lock;
  logic [ADDR_W-1:0] m1_addr;
  logic              m1_we;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_ack;
  logic              m1_err;
  logic [DATA_W-1:0] m_rdata;
  logic              bus_sel;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_we;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_trap;

  modport slave (
    input  m0_req, m0_lock, m0_addr, m0_we, m0_wdata,
    input  m1_req, m1_lock, m1_addr, m1_we, m1_wdata,
    input  bus_rdata, bus_trap,
    output m0_ack, m0_err, m1_ack, m1_err, m_rdata,
    output bus_sel, bus_addr, bus_we, bus_wdata
  );

  modport master (
    output m0_req, m0_lock, m0_addr, m0_we, m0_wdata,
    output m1_req, m1_lock, m1_addr, m1_we, m1_wdata,
    output bus_rdata, bus_trap,
    input  m0_ack, m0_err, m1_ack, m1_err, m_rdata,
    input  bus_sel, bus_addr, bus_we, bus_wdata
  );
endinterface

// File: rtl/xbus_arbiter.sv
// Round-robin two-master bus arbiter with bounded lock; req at edge N -> bus_sel cycle N+1 -> ack N+2.
// Losing master simply waits with req held; one access in flight, 3-cycle minimum spacing.
module xbus_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = 4
) (
  input logic          clk,
  input logic          rst,
  xbus_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] LOCK_MAX_C = 4'(LOCK_MAX);

  state_t            state_q;
  logic              grant_q;
  logic              last_grant_q;
  logic              lock_active_q;
  logic              lock_owner_q;
  logic [3:0]        lock_cnt_q;
  logic [3:0]        lock_cnt_d;
  logic              bus_sel_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic              bus_we_q;
  logic [DATA_W-1:0] bus_wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              m0_ack_q;
  logic              m1_ack_q;

  logic win_vld;
  logic win;
  logic win_lock;
  logic owner_lock;

  // While locked only the owner may win; otherwise alternate on a tie.
  always_comb begin
    win_vld = 1'b0;
    win     = 1'b0;
    if (lock_active_q) begin
      win     = lock_owner_q;
      win_vld = lock_owner_q ? bus.m1_req : bus.m0_req;
    end else if (bus.m0_req && bus.m1_req) begin
      win_vld = 1'b1;
      win     = ~last_grant_q;
    end else if (bus.m0_req) begin
      win_vld = 1'b1;
      win     = 1'b0;
    end else if (bus.m1_req) begin
      win_vld = 1'b1;
      win     = 1'b1;
    end
  end

  assign win_lock   = win ? bus.m1_lock : bus.m0_lock;
  assign owner_lock = lock_owner_q ? bus.m1_lock : bus.m0_lock;
  assign lock_cnt_d = lock_cnt_q + 4'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      grant_q       <= 1'b0;
      last_grant_q  <= 1'b1;
      lock_active_q <= 1'b0;
      lock_owner_q  <= 1'b0;
      lock_cnt_q    <= 4'd0;
      bus_sel_q     <= 1'b0;
      bus_addr_q    <= '0;
      bus_we_q      <= 1'b0;
      bus_wdata_q   <= '0;
      rdata_q       <= '0;
      err_q         <= 1'b0;
      m0_ack_q      <= 1'b0;
      m1_ack_q      <= 1'b0;
    end else begin
      bus_sel_q <= 1'b0;
      m0_ack_q  <= 1'b0;
      m1_ack_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (win_vld) begin
            grant_q     <= win;
            bus_addr_q  <= win ? bus.m1_addr  : bus.m0_addr;
            bus_we_q    <= win ? bus.m1_we    : bus.m0_we;
            bus_wdata_q <= win ? bus.m1_wdata : bus.m0_wdata;
            bus_sel_q   <= 1'b1;
            if (win_lock && !lock_active_q) begin
              lock_active_q <= 1'b1;
              lock_owner_q  <= win;
              lock_cnt_q    <= 4'd0;
            end
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          rdata_q  <= bus.bus_rdata;
          err_q    <= bus.bus_trap;
          m0_ack_q <= ~grant_q;
          m1_ack_q <= grant_q;
          state_q  <= DONE;
        end
        DONE: begin
          last_grant_q <= grant_q;
          if (lock_active_q) begin
            // The owner's live lock input decides release, not the value sampled at grant.
            if (!owner_lock || (lock_cnt_d == LOCK_MAX_C)) begin
              lock_active_q <= 1'b0;
              lock_cnt_q    <= 4'd0;
            end else begin
              lock_cnt_q <= lock_cnt_d;
            end
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.bus_sel   = bus_sel_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_wdata = bus_wdata_q;
  assign bus.m_rdata   = rdata_q;
  assign bus.m0_ack    = m0_ack_q;
  assign bus.m1_ack    = m1_ack_q;
  assign bus.m0_err    = m0_ack_q & err_q;
  assign bus.m1_err    = m1_ack_q & err_q;
endmodule

// File: doc/xbus_arbiter.md
Name: xbus_arbiter

Overview:
- Two-master arbiter in front of the peripheral address decoder.
- Shares the single memory-mapped bus (memory, register file, switches, buttons, LEDs, ext) between the CPU (master 0) and the external loader/debug port (master 1).
- Sequences each access as request, one-cycle select, acknowledge. Captures read data and the decoder trap flag, and returns them to the winning master.
- Grants round-robin, with an optional bounded bus lock for read-modify-write sequences.

Parameters:
- ADDR_W, `ADDR_W: bus address width.
- DATA_W, 32: bus data width.
- LOCK_MAX, 4: maximum consecutive accesses a locking master may hold the bus; range 1..15.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- m0_req  in  1  master 0 access request
- m0_lock  in  1  master 0 requests bus lock, sampled with m0_req
- m0_addr  in  ADDR_W  master 0 address
- m0_we  in  1  master 0 write enable
- m0_wdata  in  DATA_W  master 0 write data
- m0_ack  out  1  master 0 access complete, one-cycle pulse
- m0_err  out  1  master 0 access hit trap region, valid with m0_ack
- m1_req, m1_lock, m1_addr, m1_we, m1_wdata, m1_ack, m1_err: same as master 0, for master 1
- m_rdata  out  DATA_W  read data, valid while either ack is high
- bus_sel  out  1  global select to decoder
- bus_addr  out  ADDR_W  address to decoder
- bus_we  out  1  write enable to peripherals
- bus_wdata  out  DATA_W  write data to peripherals
- bus_rdata  in  DATA_W  decoder data_to_rd
- bus_trap  in  1  decoder trap_sel

Behaviour:
- Reset values: all outputs 0; state IDLE; last_grant=1, so master 0 wins the first tie; lock_active=0; lock_cnt=0.
- Reset asserted mid-access: the access is abandoned, no ack is issued, and the bus returns to IDLE.
- FSM states: IDLE, ACCESS, DONE.
- IDLE, winner selection:
  - lock_active: only lock_owner can win; the other request waits.
  - Else one request: that master wins.
  - Else both requesting: the master != last_grant wins.
- IDLE, on a win:
  - Register the winner's addr, we and wdata into bus_addr, bus_we, bus_wdata.
  - Register grant=winner.
  - If winner lock=1 and lock is not active: set lock_active=1, lock_owner=winner, lock_cnt=0.
  - Go to ACCESS. With no request, stay in IDLE with bus_sel=0.
- ACCESS:
  - bus_sel=1 for exactly one cycle; bus_addr, bus_we, bus_wdata stable.
  - Register bus_rdata into rdata_q. Register bus_trap into err_q.
  - Go to DONE.
- DONE:
  - ack for the granted master =1 for one cycle.
  - m_rdata=rdata_q, valid for reads and writes. The granted master's err=err_q.
  - last_grant=grant.
  - If lock_active: lock_cnt+1. Release (lock_active=0) when the owner's current lock input is 0, or when lock_cnt+1 == LOCK_MAX.
  - Go to IDLE.
- Outside the DONE cycle: m_rdata holds its last value; ack and err are 0.
- Latency: req high at edge N → bus_sel high in cycle N+1 → ack in cycle N+2. Minimum spacing between back-to-back accesses is 3 cycles.
- Master rules: hold req, addr, we and wdata stable until ack. Keep req high for the next access, or drop it the cycle after ack. A req dropped before ack is a protocol violation; the arbiter still completes the captured access.
- bus_sel is never asserted when no grant is held. Both acks are never high together.
- Write to a trap address: bus_sel still pulses and err=1 is returned. The arbiter does not block the access.

Test Plan:
- Single read, master 0 only: m0_req addr=0x10 (memory region), bus_rdata=0xCAFEBABE → bus_sel pulses in cycle 1; m0_ack=1, m_rdata=0xCAFEBABE, m0_err=0 in cycle 2; m1_ack stays 0.
- Simultaneous requests, held continuously, first after reset → grant order m0, m1, m0, m1. Each ack is 3 cycles apart and bus_addr alternates between the two masters' addresses.
- m1 write to the LED region, data=0xA5 → bus_we=1, bus_wdata=0xA5, bus_sel=1 in one cycle only; m1_ack follows next cycle.
- Lock with LOCK_MAX=4: m0_lock=1 for 6 accesses while m1_req is held → m0 gets 4 consecutive grants, then m1 is granted, then m0 resumes.
- Trap: m0 accesses an unmapped address with bus_trap=1 → m0_ack=1, m0_err=1. The next access to the memory region returns m0_err=0.
- Reset mid-access: assert rst low in the ACCESS cycle → bus_sel, m0_ack and m_rdata go to 0 immediately. After release, a fresh m1_req completes within 3 cycles.
